// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED breathing sequencer.
// LED_SEQ_GAMMA_EN adds the squared-duty gamma helper.
package led_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        HOLD,
        RAMP_DOWN,
        GAP
    } state_e;

    localparam logic [7:0] LVL_MAX = 8'd255;
    localparam int         NUM_CH  = 8;
    localparam int         PWM_W   = 8;

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

`ifdef LED_SEQ_GAMMA_EN
    // Cheap perceptual correction: (d*d)>>8 keeps 255 -> 254 and pushes low duties to 0.
    function automatic logic [7:0] gamma_corr(input logic [7:0] d);
        return 8'((16'(d) * 16'(d)) >> 8);
    endfunction
`endif

endpackage

// File: rtl/led_seq_ctrl_slice.sv
// One PWM channel: duty shadow reloaded only at period end, registered compare output.
module led_pwm_slice
    import led_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [PWM_W-1:0] duty_i,
    input  logic [PWM_W-1:0] cnt_i,
    output logic             led_o
);

    logic [PWM_W-1:0] shadow_q;
    logic             led_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            led_q    <= 1'b0;
        end else begin
            if (load_i)
                shadow_q <= duty_i;
            led_q <= (cnt_i < shadow_q);
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// Breathing-pattern sequencer (ramp up, hold, ramp down, gap) driving 8 phase-offset PWM LEDs.
// Define LED_SEQ_GAMMA_EN to gamma-correct channel duties; FSM and timing are unaffected.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int TICK_LEN   = 16,
    parameter int HOLD_STEPS = 64,
    parameter int GAP_STEPS  = 32,
    parameter int PHASE_STEP = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic              busy,
    output logic              done,
    output logic [7:0]        level,
    output logic [NUM_CH-1:0] led
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_STEPS - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_STEPS - 1);

    state_e              state_q;
    logic [7:0]          level_q;
    logic [7:0]          step_q;
    logic [TICK_LEN-1:0] presc_q, presc_d;
    logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic                stop_req_q;
    logic                busy_q, done_q;
    logic                tick;

    assign presc_d   = presc_q + 1'b1;
    assign pwm_cnt_d = pwm_cnt_q + 1'b1;
    assign tick      = &presc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            level_q    <= 8'd0;
            step_q     <= 8'd0;
            presc_q    <= '0;
            stop_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            presc_q <= presc_d;
            if (stop && state_q != IDLE)
                stop_req_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    stop_req_q <= 1'b0;
                    presc_q    <= '0;
                    if (start && !stop) begin
                        state_q <= RAMP_UP;
                        busy_q  <= 1'b1;
                    end
                end
                RAMP_UP: begin
                    if (stop) begin
                        state_q <= RAMP_DOWN;
                    end else if (tick) begin
                        level_q <= level_q + 8'd1;
                        if (level_q == LVL_MAX - 8'd1) begin
                            state_q <= HOLD;
                            step_q  <= 8'd0;
                        end
                    end
                end
                HOLD: begin
                    if (stop) begin
                        state_q <= RAMP_DOWN;
                    end else if (tick) begin
                        if (step_q == HOLD_LAST)
                            state_q <= RAMP_DOWN;
                        else
                            step_q <= step_q + 8'd1;
                    end
                end
                RAMP_DOWN: begin
                    // A stop taken at level 0 must not wrap, so clamp before leaving.
                    if (tick) begin
                        if (level_q <= 8'd1) begin
                            level_q <= 8'd0;
                            if (stop_req_q || stop) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= GAP;
                                step_q  <= 8'd0;
                            end
                        end else begin
                            level_q <= level_q - 8'd1;
                        end
                    end
                end
                GAP: begin
                    if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (tick) begin
                        if (step_q != GAP_LAST) begin
                            step_q <= step_q + 8'd1;
                        end else if (loop_en) begin
                            state_q <= RAMP_UP;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pwm_cnt_q <= '0;
        else
            pwm_cnt_q <= pwm_cnt_d;
    end

    logic [NUM_CH-1:0][PWM_W-1:0] duty;
    logic                         load;

    // Shadows reload on the last count so a new duty starts cleanly at pwm_cnt 0.
    assign load = (pwm_cnt_q == {PWM_W{1'b1}});

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef LED_SEQ_GAMMA_EN
        assign duty[i] = gamma_corr(sat_sub(level_q, 8'(i * PHASE_STEP)));
`else
        assign duty[i] = sat_sub(level_q, 8'(i * PHASE_STEP));
`endif
        led_pwm_slice u_slice (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (load),
            .duty_i (duty[i]),
            .cnt_i  (pwm_cnt_q),
            .led_o  (led[i])
        );
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign level = level_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with scoreboards for PWM duty, ramp-down levels and latency.
module tb_led_seq_ctrl;

    localparam int TL = 2, HS = 4, GS = 2, PS = 16;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic       busy, done;
    logic [7:0] level, led;

    int checks = 0, errors = 0, done_cnt = 0;

    led_seq_ctrl #(.TICK_LEN(TL), .HOLD_STEPS(HS), .GAP_STEPS(GS), .PHASE_STEP(PS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .busy(busy), .done(done), .level(level), .led(led)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_lvl(input logic [7:0] v, input int lim, input string tag);
        int k = 0;
        while (level !== v && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(tag, level, v);
    endtask

    // PWM scoreboard: expected duties pushed at each shadow load, checked at period end.
    typedef logic [7:0][8:0] duty_t;
    duty_t      pwm_q[$];
    logic [8:0] hi_cnt [8];
    logic [7:0] pc;
    logic       mon_en = 1'b0;

    function automatic logic [8:0] model_duty(input logic [7:0] lv, input int ch);
        int d;
        d = (int'(lv) > ch * PS) ? int'(lv) - ch * PS : 0;
`ifdef LED_SEQ_GAMMA_EN
        d = (d * d) >> 8;
`endif
        return 9'(d);
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) pc <= 8'd0;
        else        pc <= pc + 8'd1;

    always @(negedge clk) if (done) done_cnt++;

    always @(negedge clk) begin
        if (mon_en) begin
            duty_t e;
            for (int i = 0; i < 8; i++) hi_cnt[i] = hi_cnt[i] + 9'(led[i]);
            if (pc == 8'd255) begin
                for (int i = 0; i < 8; i++) e[i] = model_duty(level, i);
                pwm_q.push_back(e);
            end
            if (pc == 8'd0) begin
                if (pwm_q.size() == 0) begin
                    chk("pwm_q_empty", 0, 1);
                end else begin
                    e = pwm_q.pop_front();
                    for (int i = 0; i < 8; i++) chk($sformatf("pwm_ch%0d", i), hi_cnt[i], e[i]);
                end
                for (int i = 0; i < 8; i++) hi_cnt[i] = 9'd0;
            end
        end
    end

    int         lat_q[$];
    logic [7:0] lvl_q[$];

    initial begin
        int n, t255, d0, exp_lat;
        logic [7:0] prev, e;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_level", level, 0);
        chk("rst_led", led, 0);
        rst_n = 1'b1;

        // 1: async reset in the middle of RAMP_UP
        pulse_start();
        wait_lvl(8'd40, 400, "t1_reach40");
        chk("t1_busy", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("t1_async_led", led, 0);
        chk("t1_async_level", level, 0);
        chk("t1_async_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pwm_q.delete();
        for (int i = 0; i < 8; i++) hi_cnt[i] = 9'd0;
        pwm_q.push_back('0);
        mon_en = 1'b1;

        // 2: full single sequence timing
        @(negedge clk);
        loop_en = 1'b0;
        lat_q.push_back(2 + 1020 + 16 + 1020 + 8);
        pulse_start();
        n = 1;
        t255 = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            if (level == 8'd255 && t255 == 0) t255 = n;
        end
        exp_lat = lat_q.pop_front();
        chk("t2_done_seen", done, 1);
        chk("t2_busy_at_done", busy, 0);
        chk_rng("t2_level255_time", t255, 1019, 1021);
        chk_rng("t2_latency", n, exp_lat - 1, exp_lat + 1);
        @(negedge clk);
        chk("t2_done_pulse_width", done, 0);
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        chk("t2_done_once", done_cnt, d0);

        // 4: stop during RAMP_UP -> ramp down from same level, no GAP
        pulse_start();
        wait_lvl(8'd200, 1000, "t4_reach200");
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t4_level_kept", level, 200);
        chk("t4_busy", busy, 1);
        for (int v = 199; v >= 0; v--) lvl_q.push_back(8'(v));
        prev = 8'd200;
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
            if (level != prev) begin
                e = (lvl_q.size() != 0) ? lvl_q.pop_front() : 8'hxx;
                chk("t4_ramp_level", level, e);
                if (level == 8'd0) chk("t4_no_gap", done, 1);
                prev = level;
            end
        end
        chk("t4_done_seen", done, 1);
        chk("t4_level_zero", level, 0);
        chk("t4_all_levels_seen", lvl_q.size(), 0);
        chk_rng("t4_latency", n, 796, 800);

        // 5: looping, start ignored while busy, start&stop in IDLE
        @(negedge clk);
        loop_en = 1'b1;
        pulse_start();
        wait_lvl(8'd50, 400, "t5_reach50");
        pulse_start();
        chk("t5_busy_after_restart", busy, 1);
        chk_rng("t5_start_ignored", int'(level), 50, 51);
        d0 = done_cnt;
        wait_lvl(8'd255, 1200, "t5_reach255");
        wait_lvl(8'd0, 1200, "t5_reach0");
        wait_lvl(8'd1, 100, "t5_loop_restart");
        chk("t5_no_done_in_loop", done_cnt, d0);
        chk("t5_busy_loop", busy, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        loop_en = 1'b0;
        chk("t5_busy_after_stop", busy, 1);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_stop_done", done, 1);
        chk("t5_stop_busy", busy, 0);
        @(negedge clk);
        d0 = done_cnt;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_startstop_busy", busy, 0);
        repeat (10) @(negedge clk);
        chk("t5_startstop_idle", busy, 0);
        chk("t5_startstop_nodone", done_cnt, d0);

        // let the PWM scoreboard confirm dark outputs in IDLE
        repeat (300) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
